// File: rtl/instr_stream_if.sv
// Instruction stream bus: program load, run control and issue outputs.
// master drives load/start/mode/stall/pc; slave returns instr and status.
interface instr_stream_if #(
  parameter int N  = 16,
  parameter int AW = 5
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [N-1:0]  load_data;
  logic          start;
  logic          mode;
  logic          stall;
  logic [N-1:0]  pc;
  logic [N-1:0]  instr;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   issued_count;

  modport master (
    output load_en, load_addr, load_data,
    output start, mode, stall, pc,
    input  instr, instr_valid, busy,
    input  done, err, issued_count
  );

  modport slave (
    input  load_en, load_addr, load_data,
    input  start, mode, stall, pc,
    output instr, instr_valid, busy,
    output done, err, issued_count
  );
endinterface

// File: rtl/instr_stream_ctrl.sv
// Loadable program store issuing one instruction per cycle, sequential
// or PC-follow. Ports: clk, reset (sync, active-high), bus (slave).
module instr_stream_ctrl #(
  parameter int N = 16,
  parameter int AW = 5,
  parameter int PC_SHIFT = 1,
  parameter logic [N-1:0] HALT_WORD = 16'hFFFF,
  parameter logic [N-1:0] NOP_WORD = 16'h0000
) (
  input logic clk,
  input logic reset,
  instr_stream_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_t;

  state_t st, st_n;
  logic [N-1:0] mem [2**AW];
  logic [N-1:0] instr_q, instr_n;
  logic vld_q, vld_n;
  logic err_q, err_n;
  logic mode_q, mode_n;
  logic [15:0] cnt_q, cnt_n;
  logic [AW:0] plen_q, plen_n;
  logic [AW:0] idx_q, idx_n;

  logic we;
  logic [AW:0] ld_top;
  logic [AW-1:0] addr;
  logic [N-1:0] word;
  logic [N-1:0] pcw;
  logic oob;
  logic stop;

  // Full pc is range-checked, upper bits included.
  assign pcw = bus.pc >> PC_SHIFT;
  assign oob = pcw >= N'(plen_q);
  assign addr = mode_q ? bus.pc[PC_SHIFT +: AW]
                       : idx_q[AW-1:0];
  assign word = mem[addr];
  assign we = bus.load_en && (st != RUN);
  assign ld_top = {1'b0, bus.load_addr} + 1'b1;
  assign stop = (mode_q ? oob : (idx_q == plen_q))
             || (word == HALT_WORD);

  always_comb begin
    st_n = st;
    instr_n = instr_q;
    vld_n = vld_q;
    err_n = err_q;
    cnt_n = cnt_q;
    plen_n = plen_q;
    idx_n = idx_q;
    mode_n = mode_q;
    if (we && (ld_top > plen_q))
      plen_n = ld_top;
    unique case (st)
      IDLE, DONE: begin
        // Start decision uses the pre-load length.
        if (bus.start) begin
          err_n = 1'b0;
          cnt_n = '0;
          if (plen_q == '0) begin
            st_n = DONE;
          end else begin
            st_n = RUN;
            idx_n = '0;
            mode_n = bus.mode;
            vld_n = 1'b0;
            instr_n = NOP_WORD;
          end
        end
      end
      RUN: begin
        if (!bus.stall) begin
          unique case (1'b1)
            stop: begin
              st_n = DONE;
              instr_n = NOP_WORD;
              vld_n = 1'b0;
              err_n = err_q | (mode_q & oob);
            end
            default: begin
              instr_n = word;
              vld_n = 1'b1;
              idx_n = idx_q + 1'b1;
              if (!(&cnt_q))
                cnt_n = cnt_q + 16'd1;
            end
          endcase
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      instr_q <= NOP_WORD;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      plen_q <= '0;
      idx_q <= '0;
      mode_q <= 1'b0;
    end else begin
      st <= st_n;
      instr_q <= instr_n;
      vld_q <= vld_n;
      err_q <= err_n;
      cnt_q <= cnt_n;
      plen_q <= plen_n;
      idx_q <= idx_n;
      mode_q <= mode_n;
    end
  end

  // Store is never cleared; plen_q gates every read.
  always_ff @(posedge clk) begin
    if (we && !reset)
      mem[bus.load_addr] <= bus.load_data;
  end

  assign bus.instr = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.busy = (st == RUN);
  assign bus.done = (st == DONE);
  assign bus.err = err_q;
  assign bus.issued_count = cnt_q;
endmodule

// File: doc/instr_stream_ctrl.md
Name: instr_stream_ctrl

Overview:
Parametrised, synthesizable instruction source that feeds the controller/datapath pair one instruction per cycle from an internal loadable program store, replacing hand-timed instruction sequences. It supports two fetch modes: sequential streaming, and PC-follow, where the address is taken from the datapath pc. It also supports stall, halt-word detection, range checking and an issued-instruction counter.

Parameters:
N, 16, instruction and pc width in bits
AW, 5, program-store address width; depth = 2**AW words
PC_SHIFT, 1, pc bit offset for word addressing in PC-follow mode (store address = pc[PC_SHIFT +: AW])
HALT_WORD, 16'hFFFF, instruction word that terminates a run (N bits wide)
NOP_WORD, 16'h0000, value driven on instr whenever instr_valid=0 (N bits wide)

Ports:
clk  in  1  system clock, all state updates on its rising edge
reset  in  1  synchronous, active-high reset
load_en  in  1  write load_data into the store at load_addr; honoured only in IDLE or DONE
load_addr  in  AW  program-store write address
load_data  in  N  program-store write data
start  in  1  begin a run; sampled only in IDLE or DONE
mode  in  1  0 = sequential, 1 = PC-follow; sampled together with start and held for the run
stall  in  1  hold instr, instr_valid and the fetch index for this cycle
pc  in  N  datapath program counter, used only in PC-follow mode
instr  out  N  current instruction (registered)
instr_valid  out  1  instr holds an issued, non-halt instruction
busy  out  1  high in RUN state
done  out  1  high in DONE state
err  out  1  sticky for the run; PC-follow address >= prog_len
issued_count  out  16  instructions issued this run, saturating at 16'hFFFF

Behaviour:
- Reset (synchronous): state=IDLE; instr=NOP_WORD; instr_valid=0; busy=0; done=0; err=0; issued_count=0; prog_len=0; idx=0; run_mode=0. Store contents are not cleared; prog_len gates all reads.
- Store: 2**AW x N register array with combinational read and registered output.
- Load: when load_en is high in IDLE/DONE, mem[load_addr]<=load_data and prog_len<=max(prog_len, load_addr+1). prog_len is AW+1 bits. Ignored in RUN.
- States: IDLE, RUN, DONE. busy=(RUN), done=(DONE).
- IDLE/DONE + start at edge k:
  - If prog_len=0: go to DONE; clear err and issued_count.
  - Otherwise: go to RUN; idx=0; run_mode=mode; clear err and issued_count; instr_valid=0.
  - The first fetch occurs at edge k+1, so instr is valid after edge k+1 (one-cycle start latency).
  - If load_en and start are both high in the same cycle, the write commits and start sees the old prog_len.
- RUN fetch address: a = idx in sequential mode, a = pc[PC_SHIFT +: AW] in PC-follow mode.
- RUN, stall=1: all outputs and idx hold. stall has priority over fetch but not over reset.
- RUN, stall=0, sequential mode:
  - If idx==prog_len: go to DONE; instr=NOP_WORD; instr_valid=0.
  - Else, if mem[idx]==HALT_WORD: go to DONE; instr=NOP_WORD; instr_valid=0.
  - Else: instr<=mem[idx]; instr_valid=1; idx<=idx+1; issued_count increments (saturating).
- RUN, stall=0, PC-follow mode:
  - If the full pc maps beyond the store (pc>>PC_SHIFT >= prog_len, upper bits included): err<=1; go to DONE; instr=NOP_WORD; instr_valid=0.
  - Otherwise: same HALT/issue rules as sequential, using address a; idx is unused.
- A HALT word is never issued and never counted.
- DONE: outputs hold at their final values (NOP_WORD, instr_valid=0, done=1, err and issued_count kept) until start or reset.
- Reset mid-RUN: next edge returns to the reset state. prog_len returns to 0, so the program must be reloaded.
- idx is AW+1 bits wide, so a full 2**AW-word program ends cleanly without wrap-around.

Test Plan:
- Load 0x6208, 0x5F04, 0x5E02 at addresses 0-2, HALT_WORD at 3; start with mode=0 -> instr shows 0x6208, 0x5F04, 0x5E02 on three consecutive cycles; the next cycle gives done=1, instr_valid=0, issued_count=3, err=0.
- Same program with stall high for 2 cycles after the second word -> 0x5F04 is held for 3 cycles total; issued_count=3 at done; no word skipped or duplicated.
- Load 4 words with no HALT; start with mode=1 and drive pc=0,2,6,4 -> instr=mem[0], mem[1], mem[3], mem[2]; then pc=8 -> err=1, done=1, issued_count=4.
- Reset asserted for 1 cycle during RUN after 2 issues -> after the edge: IDLE, instr=0x0000, issued_count=0, prog_len=0; a following start goes directly to DONE with issued_count=0.
- Load all 32 addresses with non-halt words; sequential run -> exactly 32 issues, then DONE with issued_count=32; load_en pulsed during RUN leaves the store unchanged.
- load_en and start in the same cycle from IDLE with prog_len=0 -> DONE immediately; a restart then issues the newly loaded word.
